// File: rtl/controle_rpn_sequencial.sv
// RPN calculator sequencer: steps operand A, operand B, a fixed ALU wait
// and the result display, issuing one-cycle register load pulses.
// Optional ESPERA_B idle timeout is compiled in with macro RPN_TIMEOUT_EN.
module controle_rpn_sequencial #(
    parameter int LAT_ULA        = 2,
    parameter int OP_MAX         = 5,
    parameter int TIMEOUT_CICLOS = 500000000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       action_pulso,
    input  logic [2:0] sel_op,
    output logic       enable_reg_A,
    output logic       enable_reg_B,
    output logic       enable_reg_Resultado,
    output logic [1:0] estado,
    output logic       ocupado,
    output logic       erro,
    output logic [7:0] contagem_ops,
    output logic       timeout_flag
);

    localparam logic [1:0] ESPERA_A = 2'd0;
    localparam logic [1:0] ESPERA_B = 2'd1;
    localparam logic [1:0] CALCULA  = 2'd2;
    localparam logic [1:0] MOSTRA   = 2'd3;

    localparam logic [3:0] LAT_LOAD = 4'(LAT_ULA);

    // Cycles left until the ALU result is valid; expiry is the cycle with 1 left,
    // so the result pulse lands exactly LAT_ULA cycles after the B pulse.
    logic [3:0] wait_reg;
    logic       op_legal;

    assign op_legal = (32'(sel_op) <= 32'(OP_MAX));

`ifdef RPN_TIMEOUT_EN
    localparam logic [31:0] IDLE_LAST = 32'(TIMEOUT_CICLOS - 1);
    logic [31:0] idle_reg;
`endif

    // Sequencer state, registered outputs and counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            estado               <= ESPERA_A;
            enable_reg_A         <= 1'b0;
            enable_reg_B         <= 1'b0;
            enable_reg_Resultado <= 1'b0;
            ocupado              <= 1'b0;
            erro                 <= 1'b0;
            contagem_ops         <= 8'd0;
            timeout_flag         <= 1'b0;
            wait_reg             <= 4'd0;
`ifdef RPN_TIMEOUT_EN
            idle_reg             <= 32'd0;
`endif
        end else begin
            // Pulses default low so each lasts exactly one cycle
            enable_reg_A         <= 1'b0;
            enable_reg_B         <= 1'b0;
            enable_reg_Resultado <= 1'b0;
            timeout_flag         <= 1'b0;
            case (estado)
                ESPERA_A, MOSTRA: begin
                    // From MOSTRA a new operand A is entered directly
                    if (action_pulso) begin
                        enable_reg_A <= 1'b1;
                        erro         <= 1'b0;
                        estado       <= ESPERA_B;
`ifdef RPN_TIMEOUT_EN
                        idle_reg     <= 32'd0;
`endif
                    end
                end
                ESPERA_B: begin
                    // A pulse in the timeout cycle still takes the normal path
                    if (action_pulso) begin
                        enable_reg_B <= 1'b1;
                        wait_reg     <= LAT_LOAD;
                        estado       <= CALCULA;
                        ocupado      <= 1'b1;
`ifdef RPN_TIMEOUT_EN
                    end else if (idle_reg == IDLE_LAST) begin
                        estado       <= ESPERA_A;
                        timeout_flag <= 1'b1;
                        idle_reg     <= 32'd0;
                    end else begin
                        idle_reg     <= idle_reg + 32'd1;
`endif
                    end
                end
                default: begin
                    // CALCULA: action_pulso ignored; sel_op sampled only at expiry
                    if (wait_reg <= 4'd1) begin
                        wait_reg <= 4'd0;
                        ocupado  <= 1'b0;
                        estado   <= MOSTRA;
                        if (op_legal) begin
                            enable_reg_Resultado <= 1'b1;
                            contagem_ops         <= contagem_ops + 8'd1;
                        end else begin
                            erro <= 1'b1;
                        end
                    end else begin
                        wait_reg <= wait_reg - 4'd1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_controle_rpn_sequencial.sv
// Directed bench for controle_rpn_sequencial (LAT_ULA=2, OP_MAX=5, TIMEOUT_CICLOS=8).
module tb_controle_rpn_sequencial;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       action_pulso;
    logic [2:0] sel_op;
    logic       enable_reg_A;
    logic       enable_reg_B;
    logic       enable_reg_Resultado;
    logic [1:0] estado;
    logic       ocupado;
    logic       erro;
    logic [7:0] contagem_ops;
    logic       timeout_flag;

    int n_assert = 0;
    int n_fail   = 0;
    int n_flag;
    int n_res;

    controle_rpn_sequencial #(
        .LAT_ULA(2),
        .OP_MAX(5),
        .TIMEOUT_CICLOS(8)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .action_pulso(action_pulso),
        .sel_op(sel_op),
        .enable_reg_A(enable_reg_A),
        .enable_reg_B(enable_reg_B),
        .enable_reg_Resultado(enable_reg_Resultado),
        .estado(estado),
        .ocupado(ocupado),
        .erro(erro),
        .contagem_ops(contagem_ops),
        .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Apply one action pulse sampled at the next edge
    task automatic pulse();
        action_pulso = 1'b1;
        tick();
        action_pulso = 1'b0;
    endtask

    // Enable exclusivity and ocupado/estado relation on every cycle
    always @(negedge clk) begin
        if (reset_n === 1'b1) begin
            chk("onehot_en", 32'(enable_reg_A) + 32'(enable_reg_B) + 32'(enable_reg_Resultado) <= 1, 1);
            chk("ocupado_eq", 32'(ocupado), 32'(estado == 2'd2));
        end
    end

    initial begin
        reset_n      = 1'b1;
        action_pulso = 1'b0;
        sel_op       = 3'd1;
        #1 reset_n = 1'b0;
        #2;
        // Reset takes effect before any clock edge
        chk("rst_estado", 32'(estado), 0);
        chk("rst_enables", {29'd0, enable_reg_A, enable_reg_B, enable_reg_Resultado}, 0);
        chk("rst_flags", {29'd0, erro, ocupado, timeout_flag}, 0);
        chk("rst_cont", 32'(contagem_ops), 0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        repeat (3) tick();
        chk("idle_estado", 32'(estado), 0);

        // Normal operation: A, B, ignored pulse in CALCULA, result
        pulse();
        chk("a_pulse", 32'(enable_reg_A), 1);
        chk("a_estado", 32'(estado), 1);
        tick();
        chk("a_one_cycle", 32'(enable_reg_A), 0);
        pulse();
        chk("b_pulse", 32'(enable_reg_B), 1);
        chk("b_estado", 32'(estado), 2);
        sel_op       = 3'd7;   // changed away from the expiry sample: no effect
        action_pulso = 1'b1;   // ignored in CALCULA
        tick();
        action_pulso = 1'b0;
        sel_op       = 3'd1;
        chk("calc_no_en", {29'd0, enable_reg_A, enable_reg_B, enable_reg_Resultado}, 0);
        chk("calc_estado", 32'(estado), 2);
        tick();
        chk("res_pulse", 32'(enable_reg_Resultado), 1);
        chk("res_cont", 32'(contagem_ops), 1);
        chk("res_estado", 32'(estado), 3);
        chk("res_erro", 32'(erro), 0);
        tick();
        chk("res_one_cycle", 32'(enable_reg_Resultado), 0);
        chk("mostra_hold", 32'(estado), 3);

        // Illegal operation
        sel_op = 3'd7;
        pulse();
        chk("m_a_pulse", 32'(enable_reg_A), 1);
        chk("m_a_estado", 32'(estado), 1);
        pulse();
        chk("e_b_pulse", 32'(enable_reg_B), 1);
        tick();
        tick();
        chk("e_no_res", 32'(enable_reg_Resultado), 0);
        chk("e_erro", 32'(erro), 1);
        chk("e_estado", 32'(estado), 3);
        chk("e_cont", 32'(contagem_ops), 1);
        pulse();
        chk("e_clear_erro", 32'(erro), 0);
        chk("e_a_pulse", 32'(enable_reg_A), 1);
        chk("e_a_estado", 32'(estado), 1);
        sel_op = 3'd1;

        // Idle in ESPERA_B
        n_flag = 0;
        repeat (12) begin
            tick();
            if (timeout_flag === 1'b1) n_flag++;
        end
`ifdef RPN_TIMEOUT_EN
        chk("to_flag_count", 32'(n_flag), 1);
        chk("to_estado", 32'(estado), 0);
        pulse();
        chk("to_a_pulse", 32'(enable_reg_A), 1);
`else
        chk("noto_flag_count", 32'(n_flag), 0);
        chk("noto_estado", 32'(estado), 1);
`endif

        // Reset mid-CALCULA aborts without a result pulse
        pulse();
        chk("r_b_pulse", 32'(enable_reg_B), 1);
        #2 reset_n = 1'b0;
        #1;
        chk("r_estado", 32'(estado), 0);
        chk("r_cont", 32'(contagem_ops), 0);
        chk("r_enables", {29'd0, enable_reg_A, enable_reg_B, enable_reg_Resultado}, 0);
        chk("r_ocupado", 32'(ocupado), 0);
        repeat (2) @(posedge clk);
        // Pulse already high when reset releases: first sampled edge accepts it
        @(negedge clk);
        action_pulso = 1'b1;
        reset_n      = 1'b1;
        tick();
        action_pulso = 1'b0;
        chk("rel_a_pulse", 32'(enable_reg_A), 1);
        chk("rel_estado", 32'(estado), 1);
        n_res = 0;
        repeat (4) begin
            tick();
            if (enable_reg_Resultado === 1'b1) n_res++;
        end
        chk("r_no_res", 32'(n_res), 0);

        // 256 operations wrap the counter
        for (int i = 1; i <= 256; i++) begin
            pulse();
            tick();
            tick();
            if (i == 255) chk("cont_255", 32'(contagem_ops), 255);
            if (i == 256) chk("cont_wrap", 32'(contagem_ops), 0);
            pulse();
        end
        chk("wrap_estado", 32'(estado), 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Safety bound on total run time
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/controle_rpn_sequencial.md
CONTROLE_RPN_SEQUENCIAL -- requirements
Module: controle_rpn_sequencial

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, named clk and reset_n.
REQ-002 Parameter LAT_ULA, default 2, SHALL set the wait in cycles from the enable_reg_B pulse to the enable_reg_Resultado pulse (legal range 1..15).
REQ-003 Parameter OP_MAX, default 5, SHALL be the highest legal sel_op code.
REQ-004 Parameter TIMEOUT_CICLOS, default 500000000, SHALL be the idle limit in ESPERA_B (10 s at 50 MHz).
REQ-005 Ports SHALL be exactly as follows, each as name / direction / width / meaning:
- clk / in / 1 / system clock, rising edge.
- reset_n / in / 1 / asynchronous reset, active low.
- action_pulso / in / 1 / one-cycle pulse from the edge detector.
- sel_op / in / 3 / ALU operation select.
- enable_reg_A / out / 1 / one-cycle load pulse for REG_A.
- enable_reg_B / out / 1 / one-cycle load pulse for REG_B.
- enable_reg_Resultado / out / 1 / one-cycle load pulse for REG_RESULTADO.
- estado / out / 2 / current state code.
- ocupado / out / 1 / high while in CALCULA.
- erro / out / 1 / illegal-operation flag.
- contagem_ops / out / 8 / count of completed operations.
- timeout_flag / out / 1 / one-cycle pulse on timeout.

Function
REQ-006 The FSM SHALL have four states, encoded on estado as: ESPERA_A=0, ESPERA_B=1, CALCULA=2, MOSTRA=3.
REQ-007 All outputs SHALL be registered, so a response to an action_pulso sampled at edge k appears in cycle k+1.
REQ-008 In ESPERA_A, action_pulso SHALL:
- pulse enable_reg_A for one cycle;
- clear erro;
- move the FSM to ESPERA_B.
REQ-009 In ESPERA_B, action_pulso SHALL:
- pulse enable_reg_B for one cycle;
- load the wait counter with LAT_ULA;
- move the FSM to CALCULA.
REQ-010 In CALCULA, the wait counter SHALL decrement every cycle. When it expires, sel_op SHALL be sampled once:
- if sel_op <= OP_MAX, enable_reg_Resultado SHALL pulse exactly LAT_ULA cycles after the enable_reg_B pulse, and contagem_ops SHALL increment in the same cycle;
- if sel_op > OP_MAX, there SHALL be no enable_reg_Resultado pulse, erro SHALL be set to 1, and contagem_ops SHALL be unchanged;
- in both cases the FSM SHALL then move to MOSTRA.
REQ-011 action_pulso SHALL be ignored in CALCULA: no state change and no enable pulse.
REQ-012 In MOSTRA, action_pulso SHALL:
- pulse enable_reg_A;
- clear erro;
- move the FSM to ESPERA_B, so a new operand A is entered directly.
REQ-013 At most one enable output SHALL be high in any cycle.
REQ-014 contagem_ops SHALL wrap from 255 to 0 without any flag.
REQ-015 ocupado SHALL be 1 exactly when estado=2.
REQ-016 A change of sel_op outside the single expiry-cycle sample SHALL have no effect.

Reset
REQ-017 On reset_n low, the block SHALL immediately enter the following values, regardless of clock:
- estado=ESPERA_A;
- all enable outputs=0;
- erro=0, ocupado=0, timeout_flag=0;
- contagem_ops=0;
- wait and timeout counters=0.
REQ-018 A reset asserted mid-operation, including in CALCULA, SHALL abort without any enable_reg_Resultado pulse.
REQ-019 After reset_n deasserts, the first action_pulso accepted SHALL be the earliest one sampled at a rising edge with reset_n high.

Configuration
REQ-020 The timeout feature SHALL be compiled in only when macro RPN_TIMEOUT_EN is defined.
REQ-021 With RPN_TIMEOUT_EN defined:
- a 32-bit idle counter SHALL count cycles in ESPERA_B and clear on entering ESPERA_B;
- reaching TIMEOUT_CICLOS SHALL return the FSM to ESPERA_A and pulse timeout_flag for one cycle;
- an action_pulso in the same cycle as the timeout SHALL win (normal REQ-009 path, no timeout_flag).
REQ-022 Without RPN_TIMEOUT_EN, timeout_flag SHALL be tied to 0, no idle counter SHALL exist, and ESPERA_B SHALL wait indefinitely.

Verification
REQ-023 Reset, then pulses at cycles 10 and 20 with sel_op=1 and LAT_ULA=2 -> enable_reg_A in cycle 11, enable_reg_B in cycle 21, enable_reg_Resultado in cycle 23, contagem_ops=1, estado=3.
REQ-024 Pulse at cycle 22 while in CALCULA -> ignored; enable_reg_Resultado still in cycle 23 and no extra enable pulse.
REQ-025 sel_op=7 with OP_MAX=5 through the full sequence -> no enable_reg_Resultado, erro=1 in MOSTRA; the next pulse clears erro and pulses enable_reg_A.
REQ-026 256 complete operations from reset -> contagem_ops reads 0 after the 256th.
REQ-027 reset_n low in the cycle after the enable_reg_B pulse -> estado=0 at once, no enable_reg_Resultado, contagem_ops=0.
REQ-028 With RPN_TIMEOUT_EN and TIMEOUT_CICLOS=8, no pulse in ESPERA_B -> timeout_flag pulses once and estado=0; without the macro, estado stays at 1.
